// File: rtl/glitch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : glitch_pkg
// Brief    : Shared types and constants for the Wishbone glitch generator.
// Revision : 1.0 - initial release
// ============================================================================
package glitch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4
    } glitch_state_e;

    // Register offsets, in words (address bits [4:2])
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_DELAY  = 3'd1;
    localparam logic [2:0] REG_WIDTH  = 3'd2;
    localparam logic [2:0] REG_GAP    = 3'd3;
    localparam logic [2:0] REG_REPEAT = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;

    localparam int CTRL_ARM     = 0;
    localparam int CTRL_SW_TRIG = 1;
    localparam int CTRL_ABORT   = 2;
    localparam int CTRL_CLR     = 3;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_STATE_W   = 3;
    localparam int STAT_DONE_BIT  = 3;
    localparam int STAT_TOTAL_LSB = 16;
    localparam int STAT_TOTAL_W   = 16;

    function automatic logic [31:0] pack_status(
        input glitch_state_e st,
        input logic          done,
        input logic [15:0]   total
    );
        logic [31:0] s;
        s = '0;
        s[STAT_STATE_LSB +: STAT_STATE_W] = st;
        s[STAT_DONE_BIT]                  = done;
        s[STAT_TOTAL_LSB +: STAT_TOTAL_W] = total;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/glitch_seq.sv
`default_nettype none
// ============================================================================
// Module   : glitch_seq
// Brief    : Glitch sequencer FSM with delay/width/gap/repeat counters,
//            registered glitch output, sticky done and pulse totaliser.
// Revision : 1.0 - initial release
// ============================================================================
module glitch_seq
    import glitch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm_i,
    input  logic                 trig_i,
    input  logic                 abort_i,
    input  logic                 clr_i,
    input  logic [CNT_W-1:0]     delay_i,
    input  logic [CNT_W-1:0]     width_i,
    input  logic [CNT_W-1:0]     gap_i,
    input  logic [CNT_W-1:0]     repeat_i,
    output glitch_state_e        state_o,
    output logic                 busy_o,
    output logic                 glitch_o,
    output logic                 done_o,
    output logic [15:0]          pulse_total_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    glitch_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pnum_q, pnum_d;
    logic             glitch_q, glitch_d;
    logic             done_q, done_d;
    logic [15:0]      total_q, total_d;

    logic             w_pulse_end;
    logic             w_burst_end;
    logic [CNT_W-1:0] w_width_eff;
    logic [CNT_W-1:0] w_gap_eff;
    logic [CNT_W-1:0] w_repeat_eff;

    assign w_width_eff  = (width_i  == '0) ? ONE : width_i;
    assign w_gap_eff    = (gap_i    == '0) ? ONE : gap_i;
    assign w_repeat_eff = (repeat_i == '0) ? ONE : repeat_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pnum_q   <= '0;
            glitch_q <= 1'b0;
            done_q   <= 1'b0;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pnum_q   <= pnum_d;
            glitch_q <= glitch_d;
            done_q   <= done_d;
            total_q  <= total_d;
        end
    end

    // cnt_q holds remaining cycles minus one in DELAY, PULSE and GAP
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pnum_d      = pnum_q;
        w_pulse_end = 1'b0;
        w_burst_end = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm_i) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig_i) begin
                        pnum_d = '0;
                        if (delay_i == '0) begin
                            state_d = ST_PULSE;
                            cnt_d   = w_width_eff - ONE;
                        end else begin
                            state_d = ST_DELAY;
                            cnt_d   = delay_i - ONE;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == '0) begin
                        state_d = ST_PULSE;
                        cnt_d   = w_width_eff - ONE;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == '0) begin
                        w_pulse_end = 1'b1;
                        if (pnum_q == w_repeat_eff - ONE) begin
                            state_d     = ST_IDLE;
                            w_burst_end = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            cnt_d   = w_gap_eff - ONE;
                            pnum_d  = pnum_q + ONE;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_PULSE;
                        cnt_d   = w_width_eff - ONE;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // A pulse is totalled when it completes; clr overrides a coincident update
    always_comb begin
        glitch_d = (state_d == ST_PULSE);
        done_d   = done_q;
        total_d  = total_q;
        if (clr_i) begin
            done_d  = 1'b0;
            total_d = '0;
        end else begin
            if (w_burst_end) begin
                done_d = 1'b1;
            end
            if (w_pulse_end && (total_q != 16'hFFFF)) begin
                total_d = total_q + 16'd1;
            end
        end
    end

    assign state_o       = state_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign glitch_o      = glitch_q;
    assign done_o        = done_q;
    assign pulse_total_o = total_q;

endmodule
`default_nettype wire

// File: rtl/wb_glitch_gen.sv
`default_nettype none
// ============================================================================
// Module   : wb_glitch_gen
// Brief    : Wishbone-controlled glitch pulse generator. Define
//            GLITCH_EXT_TRIG_EN to enable the synchronised ext_trig input.
// Revision : 1.0 - initial release
// ============================================================================
module wb_glitch_gen
    import glitch_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
    parameter int          CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    input  logic        ext_trig,
    output logic        glitch,
    output logic        busy
);

    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] repeat_q;
    logic             ack_q;
    logic [31:0]      rdata_q, rdata_d;

    logic             w_hit;
    logic             w_wr;
    logic             w_rd;
    logic             w_ctrl_wr;
    logic             w_cfg_wr;
    logic [2:0]       w_off;
    logic             w_arm;
    logic             w_sw_trig;
    logic             w_abort;
    logic             w_clr;
    logic             w_trig;
    logic             w_busy;
    logic             w_done;
    logic [15:0]      w_total;
    glitch_state_e    w_state;
    logic [36:0]      w_unused_bits;

    assign w_hit     = i_wb_cyc && i_wb_stb && (i_wb_addr[31:8] == BASE_ADDR[31:8]);
    assign w_wr      = w_hit && i_wb_we;
    assign w_rd      = w_hit && !i_wb_we;
    assign w_off     = i_wb_addr[4:2];
    assign w_ctrl_wr = w_wr && (w_off == REG_CTRL);
    assign w_cfg_wr  = w_wr && !w_busy;

    assign w_arm     = w_ctrl_wr && i_wb_data[CTRL_ARM];
    assign w_sw_trig = w_ctrl_wr && i_wb_data[CTRL_SW_TRIG];
    assign w_abort   = w_ctrl_wr && i_wb_data[CTRL_ABORT];
    assign w_clr     = w_ctrl_wr && i_wb_data[CTRL_CLR];

    assign w_unused_bits = {i_wb_addr[7:5], i_wb_addr[1:0], i_wb_data};

`ifdef GLITCH_EXT_TRIG_EN
    logic sync1_q;
    logic sync2_q;
    logic sync3_q;
    logic edge_q;

    // Two-flop synchroniser, then a registered rising-edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= ext_trig;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q && !sync3_q;
        end
    end

    assign w_trig = w_sw_trig || edge_q;
`else
    logic w_unused_ext;

    assign w_unused_ext = ext_trig;
    assign w_trig       = w_sw_trig;
`endif

    // Timing registers only accept writes while the sequencer is idle
    always_ff @(posedge clk) begin
        if (reset) begin
            delay_q  <= '0;
            width_q  <= CNT_W'(1);
            gap_q    <= CNT_W'(1);
            repeat_q <= CNT_W'(1);
        end else if (w_cfg_wr) begin
            case (w_off)
                REG_DELAY:  delay_q  <= i_wb_data[CNT_W-1:0];
                REG_WIDTH:  width_q  <= i_wb_data[CNT_W-1:0];
                REG_GAP:    gap_q    <= i_wb_data[CNT_W-1:0];
                REG_REPEAT: repeat_q <= i_wb_data[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        case (w_off)
            REG_DELAY:  rdata_d = 32'(delay_q);
            REG_WIDTH:  rdata_d = 32'(width_q);
            REG_GAP:    rdata_d = 32'(gap_q);
            REG_REPEAT: rdata_d = 32'(repeat_q);
            REG_STATUS: rdata_d = pack_status(w_state, w_done, w_total);
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= w_hit;
            rdata_q <= w_rd ? rdata_d : 32'd0;
        end
    end

    glitch_seq #(
        .CNT_W (CNT_W)
    ) u_seq (
        .clk           (clk),
        .reset         (reset),
        .arm_i         (w_arm),
        .trig_i        (w_trig),
        .abort_i       (w_abort),
        .clr_i         (w_clr),
        .delay_i       (delay_q),
        .width_i       (width_q),
        .gap_i         (gap_q),
        .repeat_i      (repeat_q),
        .state_o       (w_state),
        .busy_o        (w_busy),
        .glitch_o      (glitch),
        .done_o        (w_done),
        .pulse_total_o (w_total)
    );

    assign o_wb_ack   = ack_q;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = rdata_q;
    assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_wb_glitch_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_glitch_gen
// Brief    : Self-checking bench for wb_glitch_gen with a timing-rule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_glitch_gen;

    localparam logic [31:0] BASE = 32'h3000_0100;
    localparam int OFF_CTRL = 0, OFF_DELAY = 1, OFF_WIDTH = 2, OFF_GAP = 3;
    localparam int OFF_REPEAT = 4, OFF_STATUS = 5;
    localparam logic [31:0] C_ARM = 32'd1, C_TRIG = 32'd2, C_ABORT = 32'd4, C_CLR = 32'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [31:0] i_wb_addr, i_wb_data;
    logic        o_wb_ack, o_wb_stall;
    logic [31:0] o_wb_data;
    logic        ext_trig, glitch, busy;

    int checks = 0;
    int errors = 0;
    int exp_total = 0;

    always #5 clk = ~clk;

    wb_glitch_gen #(.BASE_ADDR(BASE), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
        .ext_trig(ext_trig), .glitch(glitch), .busy(busy)
    );

    function automatic logic [31:0] reg_addr(input int off);
        return BASE | 32'(off << 2);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the ack cycle
    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, output logic ack);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
        i_wb_addr = addr; i_wb_data = data;
        @(posedge clk); #1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        ack = o_wb_ack;
    endtask

    task automatic wb_read(input logic [31:0] addr, output logic [31:0] data, output logic ack);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
        i_wb_addr = addr; i_wb_data = 32'd0;
        @(posedge clk); #1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        ack = o_wb_ack;
        data = o_wb_data;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        a;
        logic [31:0] exp_vals [5];
        reset = 1'b1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = reg_addr(OFF_WIDTH);
        step(3);
        checks++;
        if (o_wb_ack !== 1'b0 || o_wb_data !== 32'd0 || glitch !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b data=%h glitch=%b busy=%b, required 0/0/0/0",
                     o_wb_ack, o_wb_data, glitch, busy);
        end
        reset = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        step(1);
        exp_vals = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd0};
        for (int i = 0; i < 5; i++) begin
            wb_read(reg_addr(OFF_DELAY + i), d, a);
            checks++;
            if (a !== 1'b1 || d !== exp_vals[i]) begin
                errors++;
                $display("FAIL reset_reg%0d: ack=%b data=%h, required ack=1 data=%h", i + 1, a, d, exp_vals[i]);
            end
        end
    endtask

    task automatic test_misc;
        logic [31:0] d;
        logic        a;
        logic        seen;
        wb_write(32'h3000_0204, 32'd9, a);
        checks++;
        if (a !== 1'b0) begin
            errors++;
            $display("FAIL nomatch_ack: ack=%b, required 0", a);
        end
        wb_read(reg_addr(6), d, a);
        checks++;
        if (a !== 1'b1 || d !== 32'd0) begin
            errors++;
            $display("FAIL unmapped_read: ack=%b data=%h, required 1/0", a, d);
        end
        wb_read(reg_addr(OFF_CTRL), d, a);
        checks++;
        if (a !== 1'b1 || d !== 32'd0) begin
            errors++;
            $display("FAIL ctrl_read: ack=%b data=%h, required 1/0", a, d);
        end
        wb_write(reg_addr(OFF_CTRL), C_TRIG, a);
        seen = 1'b0;
        for (int j = 0; j < 12; j++) begin
            if (glitch !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            step(1);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL trig_in_idle: activity seen=1, required 0");
        end
        wb_write(reg_addr(OFF_CTRL), C_ARM, a);
        wb_read(reg_addr(OFF_STATUS), d, a);
        checks++;
        if (d[2:0] !== 3'd1) begin
            errors++;
            $display("FAIL armed_state: state=%0d, required 1", d[2:0]);
        end
        wb_write(reg_addr(OFF_CTRL), C_TRIG | C_ABORT, a);
        seen = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (glitch !== 1'b0) seen = 1'b1;
            step(1);
        end
        wb_read(reg_addr(OFF_STATUS), d, a);
        checks++;
        if (d[2:0] !== 3'd0 || seen) begin
            errors++;
            $display("FAIL abort_beats_trig: state=%0d glitch_seen=%b, required 0/0", d[2:0], seen);
        end
    endtask

    task automatic test_single_pulse;
        logic [31:0] d;
        logic        a;
        logic        e;
        wb_write(reg_addr(OFF_DELAY), 32'd5, a);
        wb_write(reg_addr(OFF_WIDTH), 32'd3, a);
        wb_write(reg_addr(OFF_REPEAT), 32'd1, a);
        wb_write(reg_addr(OFF_CTRL), C_CLR, a);
        wb_write(reg_addr(OFF_CTRL), C_ARM, a);
        wb_write(reg_addr(OFF_CTRL), C_TRIG, a);
        for (int j = 1; j <= 12; j++) begin
            e = (j >= 6 && j <= 8);
            checks++;
            if (glitch !== e) begin
                errors++;
                $display("FAIL single_glitch N+%0d: glitch=%b, required %b", j, glitch, e);
            end
            step(1);
        end
        wb_read(reg_addr(OFF_STATUS), d, a);
        checks++;
        if (d !== 32'h0001_0008) begin
            errors++;
            $display("FAIL single_status: status=%h, required 00010008", d);
        end
    endtask

    task automatic test_repeat;
        logic [31:0] d;
        logic        a;
        logic        e;
        int          rel;
        wb_write(reg_addr(OFF_DELAY), 32'd0, a);
        wb_write(reg_addr(OFF_WIDTH), 32'd2, a);
        wb_write(reg_addr(OFF_GAP), 32'd4, a);
        wb_write(reg_addr(OFF_REPEAT), 32'd3, a);
        wb_write(reg_addr(OFF_CTRL), C_CLR, a);
        wb_write(reg_addr(OFF_CTRL), C_ARM, a);
        wb_write(reg_addr(OFF_CTRL), C_TRIG, a);
        for (int j = 1; j <= 20; j++) begin
            rel = j - 1;
            e = (rel < 18) && ((rel % 6) < 2);
            checks++;
            if (glitch !== e) begin
                errors++;
                $display("FAIL repeat_glitch N+%0d: glitch=%b, required %b", j, glitch, e);
            end
            step(1);
        end
        wb_read(reg_addr(OFF_STATUS), d, a);
        checks++;
        if (d !== 32'h0003_0008) begin
            errors++;
            $display("FAIL repeat_status: status=%h, required 00030008", d);
        end
    endtask

    task automatic test_abort;
        logic [31:0] d;
        logic        a;
        wb_write(reg_addr(OFF_WIDTH), 32'd4, a);
        wb_write(reg_addr(OFF_GAP), 32'd2, a);
        wb_write(reg_addr(OFF_REPEAT), 32'd3, a);
        wb_write(reg_addr(OFF_CTRL), C_CLR, a);
        wb_write(reg_addr(OFF_CTRL), C_ARM, a);
        wb_write(reg_addr(OFF_CTRL), C_TRIG, a);
        step(7);
        checks++;
        if (glitch !== 1'b1) begin
            errors++;
            $display("FAIL abort_second_pulse: glitch=%b, required 1", glitch);
        end
        wb_write(reg_addr(OFF_CTRL), C_ABORT, a);
        checks++;
        if (glitch !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: glitch=%b busy=%b, required 0/0", glitch, busy);
        end
        wb_read(reg_addr(OFF_STATUS), d, a);
        checks++;
        if (d[3:0] !== 4'h0) begin
            errors++;
            $display("FAIL abort_status: state/done=%h, required 0", d[3:0]);
        end
    endtask

    task automatic test_busy_write;
        logic [31:0] d;
        logic        a;
        int          k;
        wb_write(reg_addr(OFF_DELAY), 32'd3, a);
        wb_write(reg_addr(OFF_WIDTH), 32'd3, a);
        wb_write(reg_addr(OFF_GAP), 32'd2, a);
        wb_write(reg_addr(OFF_REPEAT), 32'd2, a);
        wb_write(reg_addr(OFF_CTRL), C_ARM, a);
        wb_write(reg_addr(OFF_CTRL), C_TRIG, a);
        wb_write(reg_addr(OFF_DELAY), 32'd9, a);
        checks++;
        if (a !== 1'b1) begin
            errors++;
            $display("FAIL busy_write_ack: ack=%b, required 1", a);
        end
        wb_write(reg_addr(OFF_WIDTH), 32'd0, a);
        k = 0;
        while (busy === 1'b1 && k < 100) begin
            step(1);
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, k);
        end
        wb_read(reg_addr(OFF_DELAY), d, a);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL busy_write_delay: delay=%0d, required 3", d);
        end
        wb_read(reg_addr(OFF_WIDTH), d, a);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL busy_write_width: width=%0d, required 3", d);
        end
    endtask

    task automatic test_clr_race;
        logic [31:0] d;
        logic        a;
        wb_write(reg_addr(OFF_DELAY), 32'd0, a);
        wb_write(reg_addr(OFF_WIDTH), 32'd1, a);
        wb_write(reg_addr(OFF_REPEAT), 32'd1, a);
        wb_write(reg_addr(OFF_CTRL), C_CLR, a);
        wb_write(reg_addr(OFF_CTRL), C_ARM, a);
        wb_write(reg_addr(OFF_CTRL), C_TRIG, a);
        checks++;
        if (glitch !== 1'b1) begin
            errors++;
            $display("FAIL clr_race_pulse: glitch=%b, required 1", glitch);
        end
        wb_write(reg_addr(OFF_CTRL), C_CLR, a);
        wb_read(reg_addr(OFF_STATUS), d, a);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL clr_race_status: status=%h, required 00000000", d);
        end
    endtask

    task automatic test_ext_trig;
        logic [31:0] d;
        logic        a;
        logic        e;
        logic        seen;
`ifdef GLITCH_EXT_TRIG_EN
        wb_write(reg_addr(OFF_DELAY), 32'd2, a);
        wb_write(reg_addr(OFF_WIDTH), 32'd2, a);
        wb_write(reg_addr(OFF_REPEAT), 32'd1, a);
        wb_write(reg_addr(OFF_CTRL), C_CLR, a);
        wb_write(reg_addr(OFF_CTRL), C_ARM, a);
        ext_trig = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            e = (j == 6 || j == 7);
            checks++;
            if (glitch !== e) begin
                errors++;
                $display("FAIL ext_glitch pin+%0d: glitch=%b, required %b", j, glitch, e);
            end
            step(1);
        end
        ext_trig = 1'b0;
        step(3);
        wb_write(reg_addr(OFF_CTRL), C_TRIG, a);
        seen = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (glitch !== 1'b0) seen = 1'b1;
            step(1);
        end
        wb_read(reg_addr(OFF_STATUS), d, a);
        checks++;
        if (seen || d !== 32'h0001_0008) begin
            errors++;
            $display("FAIL ext_after: glitch_seen=%b status=%h, required 0/00010008", seen, d);
        end
`else
        wb_write(reg_addr(OFF_DELAY), 32'd0, a);
        wb_write(reg_addr(OFF_CTRL), C_ARM, a);
        ext_trig = 1'b1;
        step(3);
        ext_trig = 1'b0;
        seen = 1'b0;
        e = 1'b0;
        for (int j = 0; j < 12; j++) begin
            if (glitch !== 1'b0) seen = 1'b1;
            step(1);
        end
        checks++;
        if (seen || busy !== 1'b1) begin
            errors++;
            $display("FAIL ext_ignored: glitch_seen=%b busy=%b, required 0/1", seen, busy);
        end
        wb_write(reg_addr(OFF_CTRL), C_ABORT, a);
        checks++;
        if (busy !== e) begin
            errors++;
            $display("FAIL ext_abort: busy=%b, required 0", busy);
        end
        wb_read(reg_addr(OFF_STATUS), d, a);
`endif
    endtask

    task automatic test_random_bursts;
        logic [31:0] d;
        logic        a;
        logic        e;
        int          dl, w, g, r, we_, ge, re, per, rel, len;
        wb_write(reg_addr(OFF_CTRL), C_CLR, a);
        exp_total = 0;
        for (int it = 0; it < 8; it++) begin
            dl = $urandom_range(0, 6);
            w  = $urandom_range(0, 4);
            g  = $urandom_range(0, 4);
            r  = $urandom_range(0, 3);
            we_ = (w == 0) ? 1 : w;
            ge  = (g == 0) ? 1 : g;
            re  = (r == 0) ? 1 : r;
            per = we_ + ge;
            wb_write(reg_addr(OFF_DELAY), 32'(dl), a);
            wb_write(reg_addr(OFF_WIDTH), 32'(w), a);
            wb_write(reg_addr(OFF_GAP), 32'(g), a);
            wb_write(reg_addr(OFF_REPEAT), 32'(r), a);
            wb_read(reg_addr(OFF_WIDTH), d, a);
            checks++;
            if (d !== 32'(w)) begin
                errors++;
                $display("FAIL rand_width_rb it%0d: width=%0d, required %0d", it, d, w);
            end
            wb_write(reg_addr(OFF_CTRL), C_ARM, a);
            wb_write(reg_addr(OFF_CTRL), C_TRIG, a);
            len = 1 + dl + re * per + 2;
            for (int j = 1; j <= len; j++) begin
                rel = j - 1 - dl;
                e = (rel >= 0) && (rel < re * per) && ((rel % per) < we_);
                checks++;
                if (glitch !== e) begin
                    errors++;
                    $display("FAIL rand_glitch it%0d D=%0d W=%0d G=%0d R=%0d N+%0d: glitch=%b, required %b",
                             it, dl, w, g, r, j, glitch, e);
                end
                step(1);
            end
            exp_total += re;
            wb_read(reg_addr(OFF_STATUS), d, a);
            checks++;
            if (d !== {16'(exp_total), 16'h0008}) begin
                errors++;
                $display("FAIL rand_status it%0d: status=%h, required %h", it, d, {16'(exp_total), 16'h0008});
            end
        end
    endtask

    task automatic test_reset_midpulse;
        logic [31:0] d;
        logic        a;
        wb_write(reg_addr(OFF_DELAY), 32'd0, a);
        wb_write(reg_addr(OFF_WIDTH), 32'd8, a);
        wb_write(reg_addr(OFF_REPEAT), 32'd1, a);
        wb_write(reg_addr(OFF_CTRL), C_ARM, a);
        wb_write(reg_addr(OFF_CTRL), C_TRIG, a);
        step(2);
        checks++;
        if (glitch !== 1'b1) begin
            errors++;
            $display("FAIL midpulse_high: glitch=%b, required 1", glitch);
        end
        reset = 1'b1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = reg_addr(OFF_STATUS);
        step(1);
        checks++;
        if (glitch !== 1'b0 || o_wb_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midpulse_reset: glitch=%b ack=%b busy=%b, required 0/0/0", glitch, o_wb_ack, busy);
        end
        reset = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        step(1);
        checks++;
        if (o_wb_ack !== 1'b0) begin
            errors++;
            $display("FAIL midpulse_noack: ack=%b, required 0", o_wb_ack);
        end
        wb_read(reg_addr(OFF_WIDTH), d, a);
        checks++;
        if (d !== 32'd1 || a !== 1'b1) begin
            errors++;
            $display("FAIL midpulse_width: width=%0d ack=%b, required 1/1", d, a);
        end
    endtask

    initial begin
        reset = 1'b1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        i_wb_addr = 32'd0; i_wb_data = 32'd0;
        ext_trig = 1'b0;
        @(posedge clk); #1;
        test_reset;
        test_misc;
        test_single_pulse;
        test_repeat;
        test_abort;
        test_busy_write;
        test_clr_race;
        test_ext_trig;
        test_random_bursts;
        test_reset_midpulse;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/wb_glitch_gen.md
WB_GLITCH_GEN -- requirements
Module: wb_glitch_gen

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0100: Wishbone base address, decoded on i_wb_addr[31:8].
REQ-002 Parameter CNT_W, default 16: width of the DELAY, WIDTH, GAP and REPEAT counters.
REQ-003 clk  input  1: single clock; all logic is on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 i_wb_cyc, i_wb_stb, i_wb_we  input  1 each: Wishbone cycle, strobe and write enable.
REQ-006 i_wb_addr  input  32: Wishbone address.
REQ-007 i_wb_data  input  32: Wishbone write data.
REQ-008 o_wb_ack  output  1: request completed.
REQ-009 o_wb_stall  output  1: always 0.
REQ-010 o_wb_data  output  32: Wishbone read data.
REQ-011 ext_trig  input  1: asynchronous external trigger; used only when GLITCH_EXT_TRIG_EN is defined.
REQ-012 glitch  output  1: registered glitch pulse train, driven to the downstream hp sensor glitch input.
REQ-013 busy  output  1: high in every FSM state except IDLE.

Function
REQ-014 Register map, selected by i_wb_addr[4:2]: 0 CTRL, 1 DELAY, 2 WIDTH, 3 GAP, 4 REPEAT, 5 STATUS (read-only); unmapped offsets read 0 and ignore writes.
REQ-015 Every i_wb_cyc&i_wb_stb whose addr[31:8] matches BASE_ADDR[31:8] is acked exactly once, 1 cycle later; non-matching requests are never acked.
REQ-016 Read data is registered and valid in the ack cycle.
REQ-017 CTRL write bits: [0] arm, [1] sw_trig, [2] abort, [3] clr; all self-clearing pulses; CTRL reads 0.
REQ-018 DELAY/WIDTH/GAP/REPEAT writes take effect only in IDLE; writes in any other state are acked and discarded.
REQ-019 WIDTH, GAP and REPEAT values of 0 are treated as 1.
REQ-020 FSM states: IDLE, ARMED, DELAY, PULSE, GAP.
REQ-021 IDLE -> ARMED on arm.
REQ-022 ARMED -> DELAY on a trigger sampled in cycle N; glitch first rises in cycle N+1+DELAY (DELAY=0 enters PULSE directly).
REQ-023 glitch is high for exactly WIDTH cycles per pulse.
REQ-024 After each pulse: if fewer than REPEAT pulses have been emitted, go to GAP (glitch low for GAP cycles), then PULSE; otherwise go to IDLE and set done.
REQ-025 abort in any state -> IDLE next cycle with glitch low, done unchanged; abort wins over a simultaneous trigger or arm.
REQ-026 sw_trig outside ARMED is ignored.
REQ-027 STATUS layout: [2:0] state, [3] done (sticky), [31:16] pulse_total, a 16-bit saturating count of emitted pulses.
REQ-028 clr zeroes done and pulse_total; an increment in the same cycle is lost (clr wins).

Reset
REQ-029 While reset is high: state=IDLE; glitch=0; busy=0; o_wb_ack=0; o_wb_data=0; DELAY=0; WIDTH=1; GAP=1; REPEAT=1; done=0; pulse_total=0; synchroniser flops=0.
REQ-030 Reset mid-pulse drops glitch in the cycle following the reset edge; an in-flight Wishbone request receives no ack.

Configuration
REQ-031 Macro GLITCH_EXT_TRIG_EN defined: ext_trig passes through a 2-flop synchroniser plus rising-edge detect; the edge is a trigger in ARMED, giving a 3-cycle extra latency from the pin.
REQ-032 Macro GLITCH_EXT_TRIG_EN undefined: ext_trig is unused and sw_trig is the only trigger source.

Structure
REQ-033 Shared package glitch_pkg holds: the FSM state enum; register offset constants; CTRL bit index constants; STATUS field constants.
REQ-034 One sub-module, glitch_seq, contains the FSM, counters and glitch register.
REQ-035 The top level contains the Wishbone decode, register file and optional synchroniser.

Verification
REQ-036 Scenario: DELAY=5, WIDTH=3, REPEAT=1, arm, sw_trig in cycle N -> glitch high in cycles N+6..N+8; STATUS done=1, pulse_total=1.
REQ-037 Scenario: WIDTH=2, GAP=4, REPEAT=3 -> three 2-cycle pulses separated by 4 low cycles; pulse_total=3.
REQ-038 Scenario: abort written during the second pulse -> glitch low next cycle, state IDLE, done=0.
REQ-039 Scenario: write DELAY=9 while busy -> acked; readback after completion shows the old value.
REQ-040 Scenario: GLITCH_EXT_TRIG_EN defined, armed, ext_trig rises -> glitch rises DELAY+4 cycles after the pin edge; sw_trig in IDLE -> no pulse.
REQ-041 Scenario: glitch connected to wb_hp -> the hp alarm counter increments once per pulse and the hp alarm latch is set.
